// File: rtl/pll_pkg.sv
// Shared types and constants for the ECP5 dynamic phase-shift sequencer.
package pll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_WAIT_LOCK,
        ST_LOAD,
        ST_DONE
    } pll_phase_state_t;

    localparam logic PLL_PIN_IDLE = 1'b1;

    localparam logic [1:0] PLL_SEL_CLKOP  = 2'd0;
    localparam logic [1:0] PLL_SEL_CLKOS  = 2'd1;
    localparam logic [1:0] PLL_SEL_CLKOS2 = 2'd2;
    localparam logic [1:0] PLL_SEL_CLKOS3 = 2'd3;

endpackage

// File: rtl/pll_lock_filter.sv
// Synchronises the raw PLL LOCK and asserts lock_stable only after
// LOCK_FILTER consecutive high samples; drops on the first low sample.
module pll_lock_filter #(
    parameter int LOCK_FILTER = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked,
    output logic lock_stable
);

    localparam int CW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER + 1) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(LOCK_FILTER - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1      <= 1'b0;
            sync_2      <= 1'b0;
            cnt         <= RELOAD;
            lock_stable <= 1'b0;
        end else begin
            sync_1 <= pll_locked;
            sync_2 <= sync_1;
            if (!sync_2) begin
                cnt         <= RELOAD;
                lock_stable <= 1'b0;
            end else if (cnt == '0) begin
                lock_stable <= 1'b1;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-shift sequencer for the ECP5 EHXPLLL phase pins.
// Build option PLL_PHASE_LOCK_WAIT_EN: wait for lock after each step and pulse phaseloadreg at the end.
//
// state      | meaning
// IDLE       | ready for a request, pins at idle levels
// SETUP      | sel/dir held stable before the first step
// PULSE      | phasestep low
// GAP        | phasestep high between steps
// WAIT_LOCK  | waiting for lock_stable before continuing (option only)
// LOAD       | phaseloadreg low after the last step (option only)
// DONE       | one-cycle done pulse
module pll_phase_ctrl
    import pll_pkg::*;
#(
    parameter int NUM_OUTPUTS  = 4,
    parameter int STEP_W       = 8,
    parameter int POS_W        = 4,
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int LOCK_FILTER  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_sel,
    input  logic                         req_dir,
    input  logic [STEP_W-1:0]            req_steps,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    input  logic                         pll_locked,
    output logic                         lock_stable,
    output logic [1:0]                   phasesel,
    output logic                         phasedir,
    output logic                         phasestep,
    output logic                         phaseloadreg,
    output logic [NUM_OUTPUTS*POS_W-1:0] phase_pos
);

    localparam int CNT_W = $clog2(SETUP_CYCLES + PULSE_CYCLES + GAP_CYCLES + 1);

    pll_phase_state_t    state;
    logic [CNT_W-1:0]    cnt;
    logic [STEP_W-1:0]   rem;
    logic                err_pend;
    logic [POS_W-1:0]    pos [NUM_OUTPUTS];

    pll_lock_filter #(
        .LOCK_FILTER(LOCK_FILTER)
    ) u_lock_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .lock_stable(lock_stable)
    );

    for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_pos
        assign phase_pos[gi*POS_W +: POS_W] = pos[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            rem          <= '0;
            err_pend     <= 1'b0;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            phasesel     <= PLL_SEL_CLKOP;
            phasedir     <= PLL_PIN_IDLE;
            phasestep    <= PLL_PIN_IDLE;
            phaseloadreg <= PLL_PIN_IDLE;
            for (int i = 0; i < NUM_OUTPUTS; i++) pos[i] <= '0;
        end else begin
            // Rejections report one cycle after the offending request is seen.
            err      <= err_pend;
            err_pend <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        if (int'(req_sel) >= NUM_OUTPUTS) begin
                            err_pend <= 1'b1;
                        end else begin
                            phasesel  <= req_sel;
                            phasedir  <= req_dir;
                            rem       <= req_steps;
                            req_ready <= 1'b0;
                            busy      <= 1'b1;
                            if (req_steps == '0) begin
                                state <= ST_DONE;
                            end else begin
                                state <= ST_SETUP;
                                cnt   <= CNT_W'(SETUP_CYCLES);
                            end
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        state     <= ST_PULSE;
                        phasestep <= 1'b0;
                        cnt       <= CNT_W'(PULSE_CYCLES - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        state     <= ST_GAP;
                        phasestep <= 1'b1;
                        rem       <= rem - 1'b1;
                        cnt       <= CNT_W'(GAP_CYCLES - 1);
                        for (int i = 0; i < NUM_OUTPUTS; i++) begin
                            if (phasesel == 2'(i))
                                pos[i] <= phasedir ? pos[i] - 1'b1 : pos[i] + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
`ifdef PLL_PHASE_LOCK_WAIT_EN
                        state <= ST_WAIT_LOCK;
`else
                        if (rem != '0) begin
                            state     <= ST_PULSE;
                            phasestep <= 1'b0;
                            cnt       <= CNT_W'(PULSE_CYCLES - 1);
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef PLL_PHASE_LOCK_WAIT_EN
                ST_WAIT_LOCK: begin
                    if (lock_stable) begin
                        if (rem != '0) begin
                            state     <= ST_PULSE;
                            phasestep <= 1'b0;
                        end else begin
                            state        <= ST_LOAD;
                            phaseloadreg <= 1'b0;
                        end
                        cnt <= CNT_W'(PULSE_CYCLES - 1);
                    end
                end
                ST_LOAD: begin
                    if (cnt == '0) begin
                        state        <= ST_DONE;
                        phaseloadreg <= 1'b1;
                        done         <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    // A zero-step request enters with done low and spends one cycle raising it.
                    if (done) begin
                        state     <= ST_IDLE;
                        done      <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
